fifo_rd_stream: RTL and testbench

//  Read-side stream engine for the 8-bit gpio FIFO path. Pulls words from a FIFO read port

---
 rtl/stream_pkg.sv | 20 ++
 rtl/fifo_rd_stream_skid_buf2.sv | 59 +++++
 rtl/fifo_rd_stream.sv | 79 +++++++
 tb/tb_fifo_rd_stream.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared types and defaults for the FIFO read-side stream engine.
//   DATA_WIDTH_DEF : default FIFO word / output data width
//   CNT_WIDTH_DEF  : default transfer counter width
//   occ_t          : output buffer occupancy (0..2)
//   credit_calc    : words committed to the output buffer after this cycle
package stream_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef logic [1:0] occ_t;

  // Buffered words plus the read in flight, minus the word leaving this cycle.
  // A pop implies occ >= 1, so the result never underflows.
  function automatic logic [2:0] credit_calc(input occ_t occ, input logic inflight,
                                             input logic pop);
    return {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_buf2.sv
// Two-entry register buffer holding words between the FIFO read port and the
// output stream.
//   clk, rst     : clock, asynchronous active-low reset
//   clear        : synchronous discard of all entries (wins over push/pop)
//   push         : write push_data at tail
//   push_data    : word to store
//   pop          : retire the head entry
//   occ          : number of valid entries
//   head_data    : word at head (meaningful when occ != 0)
module skid_buf2
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output occ_t                  occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem0;
  logic [DATA_WIDTH-1:0] mem1;
  logic                  head;
  logic                  tail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem0 <= '0;
      mem1 <= '0;
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= '0;
    end else if (clear) begin
      // Stored words are left in place; they are unreachable once occ is 0.
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= '0;
    end else begin
      if (push) begin
        if (tail) mem1 <= push_data;
        else      mem0 <= push_data;
        tail <= ~tail;
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = head ? mem1 : mem0;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side stream engine: pulls words from a FIFO with one cycle of read
// latency and presents them on a valid/ready stream at up to one word per
// cycle, counting accepted transfers.
//   clk          : clock, all state on rising edge
//   rst          : asynchronous active-low reset
//   flush        : synchronous discard of buffered and in-flight words
//   fifo_empty   : FIFO empty flag
//   fifo_rd_en   : FIFO read strobe (data arrives next cycle)
//   fifo_rd_data : FIFO read data
//   out_valid    : output word available
//   out_ready    : downstream accept
//   out_data     : output word
//   xfer_cnt     : accepted words, wraps modulo 2^CNT_WIDTH
module fifo_rd_stream
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  occ_t       occ;
  logic       inflight;
  logic       pop;
  logic       push;
  logic [2:0] credit;

  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid & out_ready;
  assign credit    = credit_calc(occ, inflight, pop);

  // Issue a read only if the word can land in the buffer even with no pop
  // next cycle; rst gating keeps the strobe low during reset.
  assign fifo_rd_en = rst & ~flush & ~fifo_empty & (credit < 3'd2);

  // A word returning during flush belongs to the discarded stream.
  assign push = inflight & ~flush;

  skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .push     (push),
    .push_data(fifo_rd_data),
    .pop      (pop),
    .occ      (occ),
    .head_data(out_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  // A pop coinciding with flush was accepted downstream, so it still counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_cnt <= '0;
    end else if (pop) begin
      xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;

  wire        fifo_rd_en;
  wire        out_valid;
  wire [7:0]  out_data;
  wire [15:0] xfer_cnt;

  wire        rd_en4;
  wire        valid4;
  wire [7:0]  data4;
  wire [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fq[$];     // FIFO contents
  logic [7:0]  exp_q[$];  // words read from the FIFO, not yet delivered
  int unsigned mcnt = 0;  // accepted words since reset

  always #5 clk = ~clk;

  fifo_rd_stream u_dut (
    .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .xfer_cnt(xfer_cnt)
  );

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_en4), .fifo_rd_data(fifo_rd_data),
    .out_valid(valid4), .out_ready(out_ready), .out_data(data4),
    .xfer_cnt(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // FIFO with registered read data and registered empty flag.
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
    fifo_empty <= (fq.size() == 0);
  end

  // Scoreboard: delivered stream must equal FIFO read order minus flushed words.
  logic       prev_hold = 1'b0;
  logic       prev_flush = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_cnt", 32'(xfer_cnt), 32'd0);
      exp_q.delete();
      mcnt = 0;
      prev_hold = 1'b0;
      prev_flush = 1'b0;
    end else begin
      chk("xfer_cnt", 32'(xfer_cnt), 32'(mcnt % 65536));
      chk("xfer_cnt4", 32'(cnt4), 32'(mcnt % 16));
      if (prev_flush) chk("valid_after_flush", 32'(out_valid), 32'd0);
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        chk("pop_has_word", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        mcnt++;
      end
      if (flush) begin
        chk("rd_en_in_flush", 32'(fifo_rd_en), 32'd0);
        exp_q.delete();
      end
      if (fifo_rd_en) begin
        chk("rd_when_empty", 32'(fifo_empty), 32'd0);
        chk("rd_fifo_has_word", 32'(fq.size() != 0), 32'd1);
        if (fq.size() != 0) exp_q.push_back(fq[0]);
      end
      chk("outstanding_le2", 32'(exp_q.size() <= 2), 32'd1);
      prev_hold  = out_valid & ~out_ready & ~flush;
      prev_data  = out_data;
      prev_flush = flush;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    fq.delete();
    repeat (n) tick();
    rst = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int w;
    w = 0;
    while (!out_valid && w < 20) begin
      tick();
      w++;
    end
    chk(tag, 32'(w < 20), 32'd1);
  endtask

  initial begin
    logic       vld[16];
    logic [7:0] dat[16];
    int         first_rd;
    int         nrd;
    int         w;
    logic [15:0] cnt_save;
    logic [7:0]  nxt;

    // 1: reset with a non-empty FIFO
    rst = 1'b0;
    fq.push_back(8'h55);
    repeat (3) tick();
    chk("t1_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t1_valid", 32'(out_valid), 32'd0);
    chk("t1_data", 32'(out_data), 32'd0);
    chk("t1_cnt", 32'(xfer_cnt), 32'd0);

    // 2: latency and back-to-back streaming
    do_reset(2);
    out_ready = 1'b1;
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    first_rd = -1;
    for (int i = 0; i < 12; i++) begin
      if (fifo_rd_en && first_rd < 0) first_rd = i;
      vld[i] = out_valid;
      dat[i] = out_data;
      tick();
    end
    chk("t2_rd_seen", 32'(first_rd >= 0 && first_rd <= 7), 32'd1);
    if (first_rd >= 0 && first_rd <= 7) begin
      chk("t2_valid_n1", 32'(vld[first_rd+1]), 32'd0);
      chk("t2_valid_n2", 32'(vld[first_rd+2]), 32'd1);
      chk("t2_data0", 32'(dat[first_rd+2]), 32'h11);
      chk("t2_valid_n3", 32'(vld[first_rd+3]), 32'd1);
      chk("t2_data1", 32'(dat[first_rd+3]), 32'h22);
      chk("t2_valid_n4", 32'(vld[first_rd+4]), 32'd1);
      chk("t2_data2", 32'(dat[first_rd+4]), 32'h33);
    end
    chk("t2_cnt", 32'(xfer_cnt), 32'd3);

    // 3: backpressure limits reads to buffer capacity
    do_reset(2);
    out_ready = 1'b0;
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    nrd = 0;
    repeat (10) begin
      if (fifo_rd_en) nrd++;
      tick();
    end
    chk("t3_reads", 32'(nrd), 32'd2);
    chk("t3_rd_en_low", 32'(fifo_rd_en), 32'd0);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_data_held", 32'(out_data), 32'h11);
    chk("t3_fifo_left", 32'(fq.size()), 32'd2);
    out_ready = 1'b1;
    repeat (10) tick();
    chk("t3_cnt", 32'(xfer_cnt), 32'd4);
    chk("t3_fifo_drained", 32'(fq.size()), 32'd0);
    chk("t3_valid_end", 32'(out_valid), 32'd0);

    // 4: flush with one word buffered and one in flight
    do_reset(2);
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) fq.push_back(8'hA0 + 8'(i));
    w = 0;
    while (!fifo_rd_en && w < 10) begin
      tick();
      w++;
    end
    chk("t4_rd_start", 32'(w < 10), 32'd1);
    tick();
    tick();
    chk("t4_valid_before", 32'(out_valid), 32'd1);
    cnt_save = xfer_cnt;
    flush = 1'b1;
    #1;
    chk("t4_rd_en_flush", 32'(fifo_rd_en), 32'd0);
    tick();
    flush = 1'b0;
    chk("t4_valid_after", 32'(out_valid), 32'd0);
    chk("t4_cnt_kept", 32'(xfer_cnt), 32'(cnt_save));
    out_ready = 1'b1;
    wait_valid("t4_restart");
    chk("t4_next_word", 32'(out_data), 32'hA3);
    repeat (8) tick();

    // 5: 4-bit counter wraps after 16 pops
    do_reset(2);
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) fq.push_back(8'(i + 1));
    repeat (25) tick();
    chk("t5_cnt16", 32'(xfer_cnt), 32'd17);
    chk("t5_cnt4_wrap", 32'(cnt4), 32'd1);

    // 6: asynchronous reset mid-stream
    do_reset(2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) fq.push_back(8'hC0 + 8'(i));
    wait_valid("t6_start");
    tick();
    tick();
    #1;
    rst = 1'b0;
    #1;
    chk("t6_valid_drop", 32'(out_valid), 32'd0);
    chk("t6_fifo_nonempty", 32'(fq.size() != 0), 32'd1);
    nxt = (fq.size() != 0) ? fq[0] : 8'h00;
    tick();
    tick();
    rst = 1'b1;
    wait_valid("t6_restart");
    chk("t6_next_word", 32'(out_data), 32'(nxt));

    // Randomized traffic with flushes and occasional resets
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) == 1 && fq.size() < 16) fq.push_back(8'($urandom));
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst = 1'b0;
      tick();
    end
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();
    chk("rand_drained", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
